acc_readout: RTL and testbench
==============================

ACC_READOUT -- requirements
Module: acc_readout

Interface
REQ-001 Parameter DIM_ROW2, from DEF.sv, row count of the weight/sum array.
REQ-002 Parameter DIM_COL2, from DEF.sv, column count; N = DIM_ROW2*DIM_COL2 elements.
REQ-003 Parameter ACC_WIDTH, from DEF.sv, accumulator word width; elements are two's-complement.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to snapshot and drain the accumulator array.
REQ-007 sum  input  [N-1:0][ACC_WIDTH-1:0]  packed sums from the weight accumulator.
REQ-008 acc_clear  output  1  registered one-cycle clear pulse to the accumulator.
REQ-009 out_valid  output  1  out_data/out_idx hold a valid element.
REQ-010 out_ready  input  1  downstream accepts the element this cycle.
REQ-011 out_data  output  ACC_WIDTH  current element.
REQ-012 out_idx  output  clog2(N) (min 1)  index of current element, 0..N-1.
REQ-013 out_last  output  1  high with out_valid when out_idx == N-1.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the last element transfers.

Function
REQ-016 The FSM SHALL have states IDLE and STREAM.
REQ-017 IDLE, start=1 at edge t: capture all N sum elements into a shadow register, set idx=0, go to STREAM, drive acc_clear=1 during cycle t+1 only.
REQ-018 STREAM SHALL drive out_valid=1, out_data=shadow[idx], out_idx=idx, starting cycle t+1 (latency 1 from start).
REQ-019 Transfer occurs on an edge with out_valid && out_ready; idx SHALL then increment by 1.
REQ-020 Transfer with idx==N-1 SHALL return to IDLE, clear idx to 0, and pulse done=1 for the next cycle; out_valid SHALL be 0 that cycle.
REQ-021 While out_valid && !out_ready, out_data, out_idx and out_last SHALL stay constant.
REQ-022 start while busy=1 SHALL be ignored: no recapture, no acc_clear, idx unaffected.
REQ-023 Sum changes after capture SHALL NOT affect streamed data.
REQ-024 out_valid SHALL NOT depend combinationally on out_ready.
REQ-025 N==1: out_last=1 with the first element; done follows its transfer.
REQ-026 start and done in the same cycle: start SHALL be accepted, since the FSM is already in IDLE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, idx=0, shadow=0, and acc_clear, out_valid, out_last, busy, done = 0; out_data=0, out_idx=0.
REQ-028 Reset mid-STREAM SHALL abandon the drain; no done pulse SHALL follow reset release.

Configuration
REQ-029 Macro ACC_READOUT_RELU_EN defined: out_data SHALL be 0 when shadow[idx] is negative (MSB=1), else shadow[idx].
REQ-030 ACC_READOUT_RELU_EN undefined: out_data SHALL be shadow[idx] unmodified; all handshake timing identical in both builds.

Verification (N=4, ACC_WIDTH=16)
REQ-031 sum={4,-3,2,1} (idx0=1,idx3=4), start, out_ready=1 -> out_data 1,2,-3(0xFFFD),4 on cycles t+1..t+4; out_last at t+4; done at t+5; acc_clear only at t+1.
REQ-032 Same stream with out_ready low for 3 cycles at idx=2 -> out_data=0xFFFD and out_idx=2 stable for those cycles, then continues; no element lost or duplicated.
REQ-033 start pulsed at idx=1, sum changed after capture -> stream unchanged, no second acc_clear, single done.
REQ-034 rst_n low at idx=2 -> all outputs 0 asynchronously; after release busy=0, no done; new start streams from idx 0.
REQ-035 ACC_READOUT_RELU_EN defined, REQ-031 stimulus -> out_data 1,2,0,4; undefined -> 1,2,0xFFFD,4.
REQ-036 start asserted in the done cycle -> new capture accepted, out_valid high next cycle with idx 0.

Source files
------------

// File: rtl/acc_readout_if.sv
// Handshake and data bundle between the accumulator, acc_readout and the downstream consumer.
// master = readout side (drives stream/status), slave = environment side.
interface acc_readout_if #(
  parameter int N         = 4,
  parameter int ACC_WIDTH = 16,
  parameter int IDX_W     = (N > 1) ? $clog2(N) : 1
);
  logic                            start;
  logic [N-1:0][ACC_WIDTH-1:0]     sum;
  logic                            acc_clear;
  logic                            out_valid;
  logic                            out_ready;
  logic [ACC_WIDTH-1:0]            out_data;
  logic [IDX_W-1:0]                out_idx;
  logic                            out_last;
  logic                            busy;
  logic                            done;

  modport master (
    input  start, sum, out_ready,
    output acc_clear, out_valid, out_data, out_idx, out_last, busy, done
  );

  modport slave (
    output start, sum, out_ready,
    input  acc_clear, out_valid, out_data, out_idx, out_last, busy, done
  );
endinterface

// File: rtl/acc_readout.sv
// Snapshots the accumulator array on start and drains it one element per handshake.
// Optional build macro ACC_READOUT_RELU_EN clamps negative elements to zero on output.
//
// state  | meaning
// IDLE   | waiting for start; no element presented
// STREAM | presenting shadow[idx] until the last element is accepted
module acc_readout #(
  parameter int DIM_ROW2  = 2,
  parameter int DIM_COL2  = 2,
  parameter int ACC_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  acc_readout_if.master      bus
);
  localparam int N     = DIM_ROW2 * DIM_COL2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [N-1:0][ACC_WIDTH-1:0]     shadow_q, shadow_d;
  logic                            acc_clear_q, acc_clear_d;
  logic                            done_q, done_d;
  logic [ACC_WIDTH-1:0]            elem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      acc_clear_q <= acc_clear_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    acc_clear_d = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shadow_d    = bus.sum;
          idx_d       = '0;
          acc_clear_d = 1'b1;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        // start is deliberately not looked at here: requests while busy are dropped
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign elem = shadow_q[idx_q];

  // Outputs decode registered state only, so out_valid never sees out_ready combinationally
  assign bus.out_valid = (state_q == STREAM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign bus.acc_clear = acc_clear_q;
  assign bus.done      = done_q;

`ifdef ACC_READOUT_RELU_EN
  assign bus.out_data = elem[ACC_WIDTH-1] ? '0 : elem;
`else
  assign bus.out_data = elem;
`endif
endmodule

// File: tb/tb_acc_readout.sv
// Directed self-checking bench for acc_readout with N=4, ACC_WIDTH=16.
module tb_acc_readout;
  localparam int N  = 4;
  localparam int AW = 16;
`ifdef ACC_READOUT_RELU_EN
  localparam logic [31:0] EXP2 = 32'h0;
`else
  localparam logic [31:0] EXP2 = 32'hFFFD;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  acc_readout_if #(.N(N), .ACC_WIDTH(AW)) bus ();

  acc_readout #(.DIM_ROW2(2), .DIM_COL2(2), .ACC_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_elem(input string tag, input logic [31:0] idx, input logic [31:0] data,
                          input logic [31:0] last);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_idx"},   32'(bus.out_idx),   idx);
    chk({tag, "_data"},  32'(bus.out_data),  data);
    chk({tag, "_last"},  32'(bus.out_last),  last);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_done"},  32'(bus.done),      32'd0);
    chk({tag, "_clr"},   32'(bus.acc_clear), 32'd0);
    chk({tag, "_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_idx"},   32'(bus.out_idx),   32'd0);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum       = '0;
    #3;
    chk_all_zero("reset");
    step();
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // basic drain with ready held high
    bus.sum       = {16'd4, 16'hFFFD, 16'd2, 16'd1};
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    chk_elem("s1_e0", 0, 1, 0);
    chk("s1_clr_t1", 32'(bus.acc_clear), 1);
    chk("s1_busy", 32'(bus.busy), 1);
    step();
    chk_elem("s1_e1", 1, 2, 0);
    chk("s1_clr_t2", 32'(bus.acc_clear), 0);
    step();
    chk_elem("s1_e2", 2, EXP2, 0);
    step();
    chk_elem("s1_e3", 3, 4, 1);
    chk("s1_done_early", 32'(bus.done), 0);
    step();
    chk("s1_done", 32'(bus.done), 1);
    chk("s1_valid_off", 32'(bus.out_valid), 0);
    chk("s1_busy_off", 32'(bus.busy), 0);
    step();
    chk("s1_done_pulse", 32'(bus.done), 0);

    // backpressure for three cycles at idx 2
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_elem("s2_e0", 0, 1, 0);
    step();
    chk_elem("s2_e1", 1, 2, 0);
    step();
    chk_elem("s2_e2", 2, EXP2, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_elem("s2_hold", 2, EXP2, 0);
    end
    bus.out_ready = 1'b1;
    step();
    chk_elem("s2_e3", 3, 4, 1);
    step();
    chk("s2_done", 32'(bus.done), 1);

    // start while busy, sum changed after capture
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_elem("s3_e0", 0, 1, 0);
    chk("s3_clr", 32'(bus.acc_clear), 1);
    bus.sum = {16'd7, 16'd7, 16'd7, 16'd7};
    step();
    chk_elem("s3_e1", 1, 2, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_elem("s3_e2", 2, EXP2, 0);
    chk("s3_no_clr", 32'(bus.acc_clear), 0);
    step();
    chk_elem("s3_e3", 3, 4, 1);
    chk("s3_no_clr2", 32'(bus.acc_clear), 0);
    step();
    chk("s3_done", 32'(bus.done), 1);
    step();
    chk("s3_single_done", 32'(bus.done), 0);
    chk("s3_idle", 32'(bus.busy), 0);

    // reset in the middle of a drain
    bus.sum   = {16'd4, 16'hFFFD, 16'd2, 16'd1};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk_elem("s4_e2", 2, EXP2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("s4_async");
    step();
    rst_n = 1'b1;
    step();
    chk("s4_busy", 32'(bus.busy), 0);
    chk("s4_no_done", 32'(bus.done), 0);
    step();
    chk("s4_no_done2", 32'(bus.done), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_elem("s4_restart", 0, 1, 0);

    // start accepted in the done cycle
    step();
    step();
    step();
    chk_elem("s5_e3", 3, 4, 1);
    step();
    chk("s5_done", 32'(bus.done), 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_elem("s5_back2back", 0, 1, 0);
    chk("s5_clr", 32'(bus.acc_clear), 1);
    chk("s5_done_off", 32'(bus.done), 0);
    for (int i = 0; i < 4; i++) step();
    chk("s5_done2", 32'(bus.done), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
